aes_ctrl_seq: RTL and testbench

Parametrised round sequencer for the threshold-implementation AES datapath. It generates per-cycle phase strobes for key addition, key schedule, ShiftRows and MixColumns. It counts rounds internally instead of relying on an external last-round flag, skips MixColumns in the final round, and reports completion with a Done pulse. It also supports abort and optional stall, and drives the round-level muxing of the shared AES core.

---
 rtl/aes_ctrl_seq.sv | 215 +++++++++++++++++++++
 tb/tb_aes_ctrl_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctrl_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_ctrl_seq
//
// Round sequencer for the threshold-implementation AES datapath. Walks each
// round through the phases KA1 -> KA2 -> KA3 -> KS -> SR -> MC. The round
// counter is kept here, and MixColumns is left out of the final round. A
// one-cycle Done pulse marks the end of an encryption.
//
// Optional feature macro: AES_CTRL_STALL_EN
//   Defined   : the StallxSI port exists. StallxSI=1 freezes the sequencer.
//   Undefined : there is no StallxSI port and the sequencer never freezes.
//
// Handshake: StartxSI is a level request. It is sampled only in IDLE, and in
// DONE for a back-to-back start, and is ignored while busy. AbortxSI takes
// priority over Start and over Stall, and returns to IDLE on the next edge.
// DonexSO is high for exactly the DONE cycle, or for longer if stalled there.
//
// Ports:
//   ClkxCI                 clock, rising edge
//   RstxRI                 asynchronous active-high reset
//   StartxSI               start request
//   AbortxSI               abort, back to IDLE
//   StallxSI               freeze (only with AES_CTRL_STALL_EN)
//   StateIDLExS            in IDLE
//   State1xS               first cycle of any round
//   StateKEYADDITION1o3xS  in KA1 phase
//   StateKEYADDITION2o3xS  in KA2 phase
//   StateKEYADDITION3o3xS  in KA3 phase
//   StateKEYSCHEDULExS     in KS phase
//   StateSHIFTROWSxS       in SR phase
//   doMixColumnsxS         in MC phase
//   EndKA1xS               last cycle of KA1
//   LastCyclexS            last cycle of the current round
//   RoundxDO               current round number
//   LastRoundxSO           busy and in the final round
//   BusyxSO                neither IDLE nor DONE
//   DonexSO                completion pulse
//   StatexDO               debug: encoded FSM state
// -----------------------------------------------------------------------------
module aes_ctrl_seq #(
  parameter int KA1_CYC = 4,
  parameter int KA2_CYC = 8,
  parameter int KA3_CYC = 4,
  parameter int KS_CYC  = 3,
  parameter int SR_CYC  = 1,
  parameter int MC_CYC  = 4,
  parameter int NROUNDS = 10,
  localparam int RND_W  = $clog2(NROUNDS + 1)
) (
  input  logic             ClkxCI,
  input  logic             RstxRI,
  input  logic             StartxSI,
  input  logic             AbortxSI,
`ifdef AES_CTRL_STALL_EN
  input  logic             StallxSI,
`endif
  output logic             StateIDLExS,
  output logic             State1xS,
  output logic             StateKEYADDITION1o3xS,
  output logic             StateKEYADDITION2o3xS,
  output logic             StateKEYADDITION3o3xS,
  output logic             StateKEYSCHEDULExS,
  output logic             StateSHIFTROWSxS,
  output logic             doMixColumnsxS,
  output logic             EndKA1xS,
  output logic             LastCyclexS,
  output logic [RND_W-1:0] RoundxDO,
  output logic             LastRoundxSO,
  output logic             BusyxSO,
  output logic             DonexSO,
  output logic [2:0]       StatexDO
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The phase counter only ever has to reach the longest phase length minus one.
  localparam int PH_MAX = maxOf(maxOf(maxOf(KA1_CYC, KA2_CYC), maxOf(KA3_CYC, KS_CYC)),
                                maxOf(SR_CYC, MC_CYC));
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KA1  = 3'd1,
    KA2  = 3'd2,
    KA3  = 3'd3,
    KS   = 3'd4,
    SR   = 3'd5,
    MC   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t            StatexDP;
  logic [PH_W-1:0]   PhCntxDP;
  logic [RND_W-1:0]  RoundxDP;

  logic [PH_W-1:0]   phLastxS;
  logic              phEndxS;
  logic              stallxS;
  logic              lastRndxS;

`ifdef AES_CTRL_STALL_EN
  assign stallxS = StallxSI;
`else
  assign stallxS = 1'b0;
`endif

  // Terminal count of the phase that is currently active.
  always_comb begin
    phLastxS = '0;
    case (StatexDP)
      KA1:     phLastxS = PH_W'(KA1_CYC - 1);
      KA2:     phLastxS = PH_W'(KA2_CYC - 1);
      KA3:     phLastxS = PH_W'(KA3_CYC - 1);
      KS:      phLastxS = PH_W'(KS_CYC - 1);
      SR:      phLastxS = PH_W'(SR_CYC - 1);
      MC:      phLastxS = PH_W'(MC_CYC - 1);
      default: phLastxS = '0;
    endcase
  end

  assign phEndxS   = (PhCntxDP == phLastxS);
  assign lastRndxS = (RoundxDP == RND_W'(NROUNDS));

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      StatexDP <= IDLE;
      PhCntxDP <= '0;
      RoundxDP <= '0;
    end else if (AbortxSI) begin
      // Abort overrides Start and Stall. No Done pulse is produced.
      StatexDP <= IDLE;
      PhCntxDP <= '0;
      RoundxDP <= '0;
    end else if (!stallxS) begin
      case (StatexDP)
        IDLE: begin
          PhCntxDP <= '0;
          if (StartxSI) begin
            StatexDP <= KA1;
            RoundxDP <= RND_W'(1);
          end
        end
        KA1, KA2, KA3, KS: begin
          if (phEndxS) begin
            PhCntxDP <= '0;
            case (StatexDP)
              KA1:     StatexDP <= KA2;
              KA2:     StatexDP <= KA3;
              KA3:     StatexDP <= KS;
              default: StatexDP <= SR;
            endcase
          end else begin
            PhCntxDP <= PhCntxDP + PH_W'(1);
          end
        end
        SR: begin
          if (phEndxS) begin
            PhCntxDP <= '0;
            // The final round has no MixColumns phase.
            StatexDP <= lastRndxS ? DONE : MC;
          end else begin
            PhCntxDP <= PhCntxDP + PH_W'(1);
          end
        end
        MC: begin
          if (phEndxS) begin
            PhCntxDP <= '0;
            StatexDP <= KA1;
            RoundxDP <= RoundxDP + RND_W'(1);
          end else begin
            PhCntxDP <= PhCntxDP + PH_W'(1);
          end
        end
        DONE: begin
          PhCntxDP <= '0;
          // Start seen in DONE launches the next encryption with no IDLE gap.
          if (StartxSI) begin
            StatexDP <= KA1;
            RoundxDP <= RND_W'(1);
          end else begin
            StatexDP <= IDLE;
            RoundxDP <= '0;
          end
        end
        default: begin
          StatexDP <= IDLE;
          PhCntxDP <= '0;
          RoundxDP <= '0;
        end
      endcase
    end
  end

  // Moore outputs: every output is a decode of the registered state only.
  assign StateIDLExS           = (StatexDP == IDLE);
  assign State1xS              = (StatexDP == KA1) && (PhCntxDP == '0);
  assign StateKEYADDITION1o3xS = (StatexDP == KA1);
  assign StateKEYADDITION2o3xS = (StatexDP == KA2);
  assign StateKEYADDITION3o3xS = (StatexDP == KA3);
  assign StateKEYSCHEDULExS    = (StatexDP == KS);
  assign StateSHIFTROWSxS      = (StatexDP == SR);
  assign doMixColumnsxS        = (StatexDP == MC);
  assign EndKA1xS              = (StatexDP == KA1) && phEndxS;
  assign LastCyclexS           = ((StatexDP == SR) && phEndxS && lastRndxS) ||
                                 ((StatexDP == MC) && phEndxS);
  assign RoundxDO              = RoundxDP;
  assign BusyxSO               = (StatexDP != IDLE) && (StatexDP != DONE);
  assign LastRoundxSO          = BusyxSO && lastRndxS;
  assign DonexSO               = (StatexDP == DONE);
  assign StatexDO              = StatexDP;

endmodule

// File: tb/tb_aes_ctrl_seq.sv
`timescale 1ns/1ps
// Bench for aes_ctrl_seq: a default-parameter instance and a minimal
// instance (NROUNDS=1, MC_CYC=2, other phases 1). Round-start and Done events
// are predicted into exp_q. A negedge monitor pops the queue and compares
// whenever a DUT raises State1xS or DonexSO.
module tb_aes_ctrl_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (default parameters) ----------------
  logic start, abort, stall;
  logic idle, st1, ka1, ka2, ka3, ks, sr, mc, endka1, lastcyc, lastrnd, busy, done;
  logic [3:0] rnd;
  logic [2:0] stdbg;

  aes_ctrl_seq dut (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .AbortxSI(abort),
`ifdef AES_CTRL_STALL_EN
    .StallxSI(stall),
`endif
    .StateIDLExS(idle), .State1xS(st1),
    .StateKEYADDITION1o3xS(ka1), .StateKEYADDITION2o3xS(ka2), .StateKEYADDITION3o3xS(ka3),
    .StateKEYSCHEDULExS(ks), .StateSHIFTROWSxS(sr), .doMixColumnsxS(mc),
    .EndKA1xS(endka1), .LastCyclexS(lastcyc), .RoundxDO(rnd),
    .LastRoundxSO(lastrnd), .BusyxSO(busy), .DonexSO(done), .StatexDO(stdbg)
  );

  // ---------------- DUT (minimal parameters) ----------------
  logic s_start, s_abort, s_stall;
  logic s_idle, s_st1, s_ka1, s_ka2, s_ka3, s_ks, s_sr, s_mc, s_endka1, s_lastcyc;
  logic s_lastrnd, s_busy, s_done;
  logic [0:0] s_rnd;
  logic [2:0] s_stdbg;

  aes_ctrl_seq #(
    .KA1_CYC(1), .KA2_CYC(1), .KA3_CYC(1), .KS_CYC(1), .SR_CYC(1), .MC_CYC(2), .NROUNDS(1)
  ) dut_s (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(s_start), .AbortxSI(s_abort),
`ifdef AES_CTRL_STALL_EN
    .StallxSI(s_stall),
`endif
    .StateIDLExS(s_idle), .State1xS(s_st1),
    .StateKEYADDITION1o3xS(s_ka1), .StateKEYADDITION2o3xS(s_ka2), .StateKEYADDITION3o3xS(s_ka3),
    .StateKEYSCHEDULExS(s_ks), .StateSHIFTROWSxS(s_sr), .doMixColumnsxS(s_mc),
    .EndKA1xS(s_endka1), .LastCyclexS(s_lastcyc), .RoundxDO(s_rnd),
    .LastRoundxSO(s_lastrnd), .BusyxSO(s_busy), .DonexSO(s_done), .StatexDO(s_stdbg)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {kind[1:0], round[3:0], cycle[25:0]}
  // kind 0 = main round start, 1 = main done, 2 = small round start, 3 = small done
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic s_mc_seen   = 1'b0;
  logic mc_in_last  = 1'b0;

  function automatic logic [31:0] mk(input int kind, input int r, input int c);
    logic [31:0] v;
    v = {kind[1:0], r[3:0], c[25:0]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic mon_cmp(input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event at cycle %0d: got 0x%0h, expected no event", cyc, act);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard_event", act, e);
    end
  endtask

  always @(negedge clk) begin
    if (st1)    mon_cmp(mk(0, int'(rnd), cyc));
    if (done)   mon_cmp(mk(1, int'(rnd), cyc));
    if (s_st1)  mon_cmp(mk(2, int'(s_rnd), cyc));
    if (s_done) mon_cmp(mk(3, int'(s_rnd), cyc));
    if (s_mc) s_mc_seen = 1'b1;
    if (mc && rnd == 4'd10) mc_in_last = 1'b1;
  end

  // Watchdog: every wait below is bounded by this cycle budget.
  always @(negedge clk) begin
    if (cyc > 6000) begin
      n_fail++;
      $display("FAIL watchdog: cycle %0d exceeded budget 6000", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Round r of a default encryption started at t begins at t+1+(r-1)*24.
  // Rounds at or after shift_from are delayed by shift cycles (stall).
  task automatic exp_rounds(input int t, input int last_r, input int shift_from, input int shift);
    for (int r = 1; r <= last_r; r++)
      exp_q.push_back(mk(0, r, t + 1 + (r - 1) * 24 + ((r >= shift_from) ? shift : 0)));
  endtask

  task automatic exp_done(input int t, input int shift);
    exp_q.push_back(mk(1, 10, t + 237 + shift));
  endtask

  // ---------------- stimulus ----------------
  int t, t2, t3, t4, t5, ts;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_idle", idle, 1'b1);
    check("reset_round", rnd, 4'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_strobes", {st1, ka1, ka2, ka3, ks, sr, mc, endka1, lastcyc, lastrnd}, 10'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", idle, 1'b1);

    // Run 1: Start held high from here through DONE, giving a back-to-back run 2.
    t = cyc; start = 1'b1;
    t2 = t + 237;
    exp_rounds(t, 10, 99, 0);
    exp_done(t, 0);
    exp_rounds(t2, 5, 99, 0);
    wait_cyc(t + 1);   check("r1_ka1", {ka1, stdbg}, {1'b1, 3'd1});
    check("r1_round", rnd, 4'd1);
    wait_cyc(t + 4);   check("r1_endka1", endka1, 1'b1);
    wait_cyc(t + 5);   check("r1_ka2", {ka2, endka1}, 2'b10);
    wait_cyc(t + 13);  check("r1_ka3", ka3, 1'b1);
    wait_cyc(t + 17);  check("r1_ks", ks, 1'b1);
    wait_cyc(t + 20);  check("r1_sr_not_last", {sr, lastcyc}, 2'b10);
    wait_cyc(t + 21);  check("r1_mc", mc, 1'b1);
    wait_cyc(t + 24);  check("r1_mc_lastcycle", {mc, lastcyc}, 2'b11);
    wait_cyc(t + 217); check("r10_lastround", {lastrnd, rnd}, {1'b1, 4'd10});
    wait_cyc(t + 236); check("r10_sr_lastcycle", {sr, lastcyc, mc}, 3'b110);
    wait_cyc(t + 237); check("done_state", {done, busy, lastrnd, stdbg}, {3'b100, 3'd7});
    check("done_round", rnd, 4'd10);
    wait_cyc(t + 238); check("back_to_back", {idle, st1, rnd}, {2'b01, 4'd1});

    // Abort together with Start in round 5, KA2 of run 2.
    wait_cyc(t2 + 103); check("r5_ka2", {ka2, rnd}, {1'b1, 4'd5});
    abort = 1'b1;
    wait_cyc(t2 + 104); check("abort_idle", {idle, busy, done, rnd}, {3'b100, 4'd0});
    abort = 1'b0; start = 1'b0;
    wait_cyc(t2 + 105); check("abort_stays_idle", idle, 1'b1);

    // Run 3: full encryption after the abort.
    @(negedge clk); t3 = cyc; start = 1'b1;
    exp_rounds(t3, 10, 99, 0);
    exp_done(t3, 0);
    @(negedge clk); start = 1'b0;
    wait_cyc(t3 + 237); check("run3_done", done, 1'b1);
    wait_cyc(t3 + 238); check("run3_idle", {idle, busy, done, rnd}, {3'b100, 4'd0});

    // Run 4: reset pulse in KS of round 3.
    @(negedge clk); t4 = cyc; start = 1'b1;
    exp_rounds(t4, 3, 99, 0);
    @(negedge clk); start = 1'b0;
    wait_cyc(t4 + 66); check("r3_ks", {ks, rnd}, {1'b1, 4'd3});
    #2 rst = 1'b1; start = 1'b1;
    #1 check("async_reset", {idle, ks, busy, rnd}, {3'b100, 4'd0});
    repeat (2) @(negedge clk);
    check("start_ignored_in_reset", {idle, busy}, 2'b10);
    start = 1'b0; rst = 1'b0;
    @(negedge clk); check("idle_after_mid_reset", {idle, rnd}, {1'b1, 4'd0});

`ifdef AES_CTRL_STALL_EN
    // Run 5: stall three cycles in MC of round 2.
    @(negedge clk); t5 = cyc; start = 1'b1;
    exp_rounds(t5, 10, 3, 3);
    exp_done(t5, 3);
    @(negedge clk); start = 1'b0;
    wait_cyc(t5 + 46); check("r2_mc", {mc, rnd}, {1'b1, 4'd2});
    stall = 1'b1;
    wait_cyc(t5 + 49); check("stall_frozen", {mc, lastcyc, rnd, stdbg}, {2'b10, 4'd2, 3'd6});
    stall = 1'b0;
    wait_cyc(t5 + 51); check("stall_mc_lastcycle", {mc, lastcyc}, 2'b11);
    wait_cyc(t5 + 240); check("stall_done", done, 1'b1);
    wait_cyc(t5 + 241); check("stall_idle", idle, 1'b1);
`endif

    // Minimal instance: one round, no MixColumns.
    @(negedge clk); ts = cyc; s_start = 1'b1;
    exp_q.push_back(mk(2, 1, ts + 1));
    exp_q.push_back(mk(3, 1, ts + 6));
    @(negedge clk); s_start = 1'b0;
    check("s_ka1", {s_ka1, s_endka1, s_lastrnd}, 3'b111);
    wait_cyc(ts + 2); check("s_ka2", s_ka2, 1'b1);
    wait_cyc(ts + 3); check("s_ka3", s_ka3, 1'b1);
    wait_cyc(ts + 4); check("s_ks", s_ks, 1'b1);
    wait_cyc(ts + 5); check("s_sr_last", {s_sr, s_lastcyc}, 2'b11);
    wait_cyc(ts + 6); check("s_done", {s_done, s_busy}, 2'b10);
    wait_cyc(ts + 7); check("s_idle", {s_idle, s_rnd}, 2'b10);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("s_no_mixcolumns", s_mc_seen, 1'b0);
    check("no_mc_in_final_round", mc_in_last, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
